axi_lite_uart_ctrl: RTL and testbench
=====================================

Name: axi_lite_uart_ctrl

Overview:
- AXI4-Lite slave that wraps an 8N1 UART transmitter and receiver behind a four-register map.
- Sits on the processor peripheral bus; TXD/RXD go to pads or are looped back for self-test.
- One clock domain. Baud rate is set by a programmable clocks-per-bit divisor.

Parameters:
- P_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- P_S_AXI_ADDR_WIDTH, 32, AXI address width; only ADDR[3:2] is decoded.
- P_CLKS_PER_BIT, 16, reset value of the BAUD register; must be at least 4.

Ports:
- S_AXI_ACLK  in  1  clock; all logic is on the rising edge.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  ADDR_W  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID in 1, S_AXI_WREADY out 1: write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID out 1, S_AXI_BREADY in 1: write-response handshake.
- S_AXI_ARADDR  in  ADDR_W  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID out 1, S_AXI_RREADY in 1: read-data handshake.
- RXD  in  1  serial input; asynchronous, idle high.
- TXD  out  1  serial output; idle high.

Behaviour:
- Reset values: all READY/VALID outputs 0; RDATA 0; BRESP/RRESP 0; TXD 1; BAUD = P_CLKS_PER_BIT; rx_valid, overrun and frame_err cleared; TX and RX FSMs in IDLE.
- Register map (byte offset, ADDR[3:2]):
  - 0x0 RXDATA (RO): [7:0] last received byte, [8] rx_valid. A read clears rx_valid and overrun.
  - 0x4 TXDATA (WO): a write with WSTRB[0]=1 while TX is idle launches WDATA[7:0]. A write while busy is dropped. Reads return 0.
  - 0x8 STATUS (RO): [0] tx_busy, [1] rx_valid, [2] overrun, [3] frame_err. A read clears frame_err.
  - 0xC BAUD (RW): [15:0] clocks per bit, byte-strobed. Writes of value <4 are clamped to 4.
- Write channel: AW and W are accepted independently, in either order or in the same cycle.
  - AWREADY pulses 1 cycle when AWVALID=1 and no address is latched; the address is latched then.
  - WREADY pulses 1 cycle when WVALID=1 and no data is latched; the data is latched then.
  - The register update happens the cycle after both are latched. BVALID rises in that same cycle.
  - BVALID holds until BREADY=1, then both latches clear. No new AW/W is accepted while BVALID=1.
- Read channel:
  - ARREADY pulses 1 cycle when ARVALID=1 and RVALID=0.
  - RVALID and RDATA are valid on the next cycle; RDATA is held stable until RREADY=1.
  - Read side effects (clearing flags) happen at the AR handshake.
- TX FSM: IDLE → START → DATA×8 (LSB first) → STOP → IDLE. Each bit lasts BAUD cycles.
  - TXD goes low on the cycle after the launching register write.
  - tx_busy = 1 from launch until the end of the stop bit.
- RX path: RXD passes through a 2-flop synchronizer.
  - RX FSM: IDLE detects a falling edge → START samples at BAUD/2. If the line is high, this is a glitch: return to IDLE.
  - DATA samples each bit at mid-bit (every BAUD cycles) → STOP samples at mid-bit.
  - On the STOP sample, store the byte and set rx_valid. If the stop bit is 0, also set frame_err; the byte is still stored.
  - If rx_valid was already 1 when a new byte completes, set overrun and overwrite the byte.
  - After the STOP sample, return to IDLE (re-arms for the next start bit).
- Simultaneous RX completion and RXDATA read: the set wins. The new byte stays valid and overrun stays clear.
- A BAUD write takes effect on the next frame; frames in flight keep their latched divisor.
- Reset mid-frame: TXD returns high immediately (asynchronous); a partial RX frame is discarded.

Test Plan:
- Reset, then read 0xC → RDATA=0x10; read 0x8 → 0x0; TXD=1.
- TXD looped to RXD. Write AW 0x4, then W 0x6 with WSTRB=0xF one cycle later → AWREADY then WREADY each pulse once; BVALID held until BREADY, BRESP=0. An immediate read of 0x0 → 0x000.
- Same loopback: poll 0x8 until bit1=1, roughly 160 cycles later → read 0x0 returns 0x106; a second read returns 0x006.
- Write 0x55 then 0xAA back-to-back without reading → 0xAA is dropped (busy). After one frame, STATUS=0x2.
- Send two bytes 0x12 and 0x34 without reading → STATUS=0x6; RXDATA=0x134.
- Drive an RXD frame with stop bit 0 → STATUS bit3=1; reading STATUS clears it. Write BAUD=2 → readback is 4.

Source files
------------

// File: rtl/axi_lite_uart_ctrl.sv
// AXI4-Lite slave exposing an 8N1 UART transmitter and receiver through four
// registers: RXDATA (0x0), TXDATA (0x4), STATUS (0x8) and BAUD (0xC).
// The baud divisor is latched at the start of each frame, so reprogramming
// BAUD never disturbs a frame that is already on the wire.
module axi_lite_uart_ctrl #(
    parameter int P_S_AXI_DATA_WIDTH = 32,
    parameter int P_S_AXI_ADDR_WIDTH = 32,
    parameter int P_CLKS_PER_BIT     = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [P_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [P_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [P_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [P_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [P_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            RXD,
    output logic                            TXD
);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic                          clk;
    logic                          rst;
    assign clk = S_AXI_ACLK;
    assign rst = S_AXI_ARESET;

    // Write channel state
    logic                          awready_q;
    logic                          wready_q;
    logic                          bvalid_q;
    logic                          aw_latched;
    logic                          w_latched;
    logic [1:0]                    aw_addr_q;
    logic [15:0]                   wdata_q;
    logic [1:0]                    wstrb_q;
    logic                          wr_fire;

    // Read channel state
    logic                          arready_q;
    logic                          rvalid_q;
    logic [P_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [P_S_AXI_DATA_WIDTH-1:0] rd_mux;
    logic                          rd_hs;
    logic                          rd_rxdata;
    logic                          rd_status;

    // Baud divisor
    logic [15:0]                   baud;
    logic [15:0]                   baud_merge;
    logic [15:0]                   baud_next;

    // Transmitter
    tx_state_t                     tx_state;
    logic [15:0]                   tx_cnt;
    logic [15:0]                   tx_baud;
    logic [7:0]                    tx_shift;
    logic [2:0]                    tx_idx;
    logic                          txd_q;
    logic                          tx_busy;
    logic                          tx_launch;
    logic                          tx_bit_end;

    // Receiver
    rx_state_t                     rx_state;
    logic [15:0]                   rx_cnt;
    logic [15:0]                   rx_baud;
    logic [15:0]                   rx_half;
    logic [7:0]                    rx_shift;
    logic [2:0]                    rx_idx;
    logic                          rxd_s1;
    logic                          rxd_s2;
    logic                          rxd_prev;
    logic                          rx_done;
    logic [7:0]                    rx_byte;
    logic                          rx_valid;
    logic                          overrun;
    logic                          frame_err;

    logic                          unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[P_S_AXI_ADDR_WIDTH-1:4], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[P_S_AXI_ADDR_WIDTH-1:4], S_AXI_ARADDR[1:0],
                           S_AXI_WDATA[P_S_AXI_DATA_WIDTH-1:16],
                           S_AXI_WSTRB[P_S_AXI_DATA_WIDTH/8-1:2]};

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign TXD           = txd_q;

    assign wr_fire    = aw_latched && w_latched && !bvalid_q;
    assign tx_busy    = (tx_state != TX_IDLE);
    assign tx_launch  = wr_fire && (aw_addr_q == 2'd1) && wstrb_q[0] && !tx_busy;
    assign tx_bit_end = (tx_cnt == tx_baud - 16'd1);
    assign rx_half    = {1'b0, rx_baud[15:1]};
    assign rx_done    = (rx_state == RX_STOP) && (rx_cnt == rx_baud - 16'd1);
    assign rd_hs      = arready_q && S_AXI_ARVALID;
    assign rd_rxdata  = rd_hs && (S_AXI_ARADDR[3:2] == 2'd0);
    assign rd_status  = rd_hs && (S_AXI_ARADDR[3:2] == 2'd2);

    // Accept AW and W independently, then issue one response once both are held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            aw_latched <= 1'b0;
            w_latched  <= 1'b0;
            aw_addr_q  <= 2'd0;
            wdata_q    <= 16'd0;
            wstrb_q    <= 2'd0;
        end else begin
            awready_q <= S_AXI_AWVALID && !awready_q && !aw_latched && !bvalid_q;
            wready_q  <= S_AXI_WVALID && !wready_q && !w_latched && !bvalid_q;
            if (awready_q && S_AXI_AWVALID) begin
                aw_latched <= 1'b1;
                aw_addr_q  <= S_AXI_AWADDR[3:2];
            end
            if (wready_q && S_AXI_WVALID) begin
                w_latched <= 1'b1;
                wdata_q   <= S_AXI_WDATA[15:0];
                wstrb_q   <= S_AXI_WSTRB[1:0];
            end
            if (wr_fire) begin
                bvalid_q <= 1'b1;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q   <= 1'b0;
                aw_latched <= 1'b0;
                w_latched  <= 1'b0;
            end
        end
    end

    // Byte-strobed merge into BAUD with a floor of four clocks per bit
    always_comb begin
        baud_merge = baud;
        if (wstrb_q[0]) baud_merge[7:0]  = wdata_q[7:0];
        if (wstrb_q[1]) baud_merge[15:8] = wdata_q[15:8];
        baud_next = (baud_merge < 16'd4) ? 16'd4 : baud_merge;
    end

    // BAUD register update on a completed write to offset 0xC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud <= 16'(P_CLKS_PER_BIT);
        end else if (wr_fire && (aw_addr_q == 2'd3)) begin
            baud <= baud_next;
        end
    end

    // Register read multiplexer, evaluated at the AR handshake
    always_comb begin
        rd_mux = '0;
        case (S_AXI_ARADDR[3:2])
            2'd0:    rd_mux[8:0]  = {rx_valid, rx_byte};
            2'd2:    rd_mux[3:0]  = {frame_err, overrun, rx_valid, tx_busy};
            2'd3:    rd_mux[15:0] = baud;
            default: rd_mux       = '0;
        endcase
    end

    // Read channel: one outstanding read, data held until RREADY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= S_AXI_ARVALID && !arready_q && !rvalid_q;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Transmit FSM: start bit, eight data bits LSB first, stop bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 16'd0;
            tx_baud  <= 16'(P_CLKS_PER_BIT);
            tx_shift <= 8'd0;
            tx_idx   <= 3'd0;
            txd_q    <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    txd_q  <= 1'b1;
                    tx_cnt <= 16'd0;
                    if (tx_launch) begin
                        tx_state <= TX_START;
                        txd_q    <= 1'b0;
                        tx_shift <= wdata_q[7:0];
                        tx_baud  <= baud;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= 16'd0;
                        txd_q    <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_idx   <= 3'd0;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= 16'd0;
                        if (tx_idx == 3'd7) begin
                            txd_q    <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            txd_q    <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_idx   <= tx_idx + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= 16'd0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // Two-flop synchronizer for RXD plus a delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_s1   <= RXD;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
        end
    end

    // Receive FSM: falling edge, verify start at half-bit, then mid-bit samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_baud  <= 16'(P_CLKS_PER_BIT);
            rx_shift <= 8'd0;
            rx_idx   <= 3'd0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= 16'd0;
                    if (rxd_prev && !rxd_s2) begin
                        rx_state <= RX_START;
                        rx_baud  <= baud;
                    end
                end
                RX_START: begin
                    if (rx_cnt == rx_half - 16'd1) begin
                        rx_cnt   <= 16'd0;
                        rx_idx   <= 3'd0;
                        rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == rx_baud - 16'd1) begin
                        rx_cnt   <= 16'd0;
                        rx_shift <= {rxd_s2, rx_shift[7:1]};
                        if (rx_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (rx_done) begin
                        rx_cnt   <= 16'd0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // Received byte and sticky flags; a completing frame beats a clearing read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_byte   <= 8'd0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_done) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rd_rxdata) begin
                rx_valid <= 1'b0;
            end
            if (rd_rxdata) begin
                overrun <= 1'b0;
            end else if (rx_done && rx_valid) begin
                overrun <= 1'b1;
            end
            if (rx_done && !rxd_s2) begin
                frame_err <= 1'b1;
            end else if (rd_status) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_uart_ctrl.sv
// Directed bench for axi_lite_uart_ctrl. Bus tasks push the expected BRESP
// and RDATA into queues; a monitor on the falling edge pops and compares each
// time a B or R handshake is presented. TXD can be looped back to RXD.
module tb_axi_lite_uart_ctrl;

    typedef struct {
        logic [31:0] data;
        bit          chk;
    } rd_exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        rxd_line;
    logic        rxd_drive;
    logic        loopback;
    logic        txd;

    int          tests_run  = 0;
    int          fail_count = 0;
    int          aw_hs      = 0;
    int          w_hs       = 0;
    rd_exp_t     rq[$];
    logic [1:0]  bq[$];
    logic [31:0] rd_dummy;

    assign rxd_line = loopback ? txd : rxd_drive;

    axi_lite_uart_ctrl dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .RXD           (rxd_line),
        .TXD           (txd)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: count address/data handshakes and score B and R responses
    always @(negedge clk) begin
        if (awvalid && awready) aw_hs++;
        if (wvalid && wready) w_hs++;
        if (bvalid && bready) begin
            if (bq.size() == 0) begin
                checkOutput("unexpected_bresp", {31'b0, bvalid}, 32'd0);
            end else begin
                checkOutput("bresp", {30'b0, bresp}, {30'b0, bq.pop_front()});
            end
        end
        if (rvalid && rready) begin
            if (rq.size() == 0) begin
                checkOutput("unexpected_rvalid", {31'b0, rvalid}, 32'd0);
            end else begin
                rd_exp_t e;
                e = rq.pop_front();
                if (e.chk) begin
                    checkOutput("rdata", rdata, e.data);
                    checkOutput("rresp", {30'b0, rresp}, 32'd0);
                end
            end
        end
    end

    task automatic drive_aw(input logic [31:0] addr, input int dly);
        bit got;
        got = 0;
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
        end
        awaddr  = addr;
        awvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready) begin
                got = 1;
                break;
            end
        end
        if (got) begin
            @(posedge clk);
            #1;
        end
        awvalid = 1'b0;
        if (!got) checkOutput("awready_timeout", {31'b0, awready}, 32'd1);
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
        bit got;
        got = 0;
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
        end
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wready) begin
                got = 1;
                break;
            end
        end
        if (got) begin
            @(posedge clk);
            #1;
        end
        wvalid = 1'b0;
        if (!got) checkOutput("wready_timeout", {31'b0, wready}, 32'd1);
    endtask

    // Full write: AW and W with independent delays, optional BREADY stall
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int bready_dly);
        int aw0;
        int w0;
        bit got;
        aw0 = aw_hs;
        w0  = w_hs;
        got = 0;
        fork
            drive_aw(addr, aw_dly);
            drive_w(data, strb, w_dly);
        join
        bq.push_back(2'b00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bvalid) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checkOutput("bvalid_timeout", {31'b0, bvalid}, 32'd1);
            bq.delete();
        end else begin
            for (int i = 0; i < bready_dly; i++) begin
                @(negedge clk);
                checkOutput("bvalid_hold", {31'b0, bvalid}, 32'd1);
            end
            @(posedge clk);
            #1 bready = 1'b1;
            @(posedge clk);
            #1 bready = 1'b0;
        end
        checkOutput("aw_handshakes", aw_hs - aw0, 32'd1);
        checkOutput("w_handshakes", w_hs - w0, 32'd1);
    endtask

    // Full read; chk=0 marks a poll whose value only steers the sequence
    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input bit chk,
                            input int rready_dly, output logic [31:0] data);
        bit      got;
        rd_exp_t e;
        data    = '0;
        got     = 0;
        araddr  = addr;
        arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready) begin
                got = 1;
                break;
            end
        end
        if (got) begin
            @(posedge clk);
            #1;
        end
        arvalid = 1'b0;
        if (!got) begin
            checkOutput("arready_timeout", {31'b0, arready}, 32'd1);
            return;
        end
        e.data = exp;
        e.chk  = chk;
        rq.push_back(e);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid) begin
                got  = 1;
                data = rdata;
                break;
            end
        end
        if (!got) begin
            checkOutput("rvalid_timeout", {31'b0, rvalid}, 32'd1);
            rq.delete();
            return;
        end
        repeat (rready_dly) @(posedge clk);
        @(posedge clk);
        #1 rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp);
        axi_read(addr, exp, 1'b1, 0, rd_dummy);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        axi_write(addr, data, 4'hF, 0, 0, 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bit-bang one 8N1 frame on RXD at 16 clocks per bit
    task automatic send_rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_drive = frame[i];
            idle_cycles(16);
        end
        rxd_drive = 1'b1;
    endtask

    task automatic poll_rx_valid();
        logic [31:0] st;
        st = '0;
        for (int i = 0; i < 100 && !st[1]; i++) begin
            axi_read(32'h8, 32'h0, 1'b0, 0, st);
        end
        checkOutput("poll_rx_valid", {31'b0, st[1]}, 32'd1);
    endtask

    // Directed sequence with hand-computed expectations
    task automatic applyStimulus();
        // Reset values
        rd_chk(32'hC, 32'h10);
        rd_chk(32'h8, 32'h0);
        rd_chk(32'h4, 32'h0);
        checkOutput("txd_idle", {31'b0, txd}, 32'd1);

        // Loopback send of 0x06, W one cycle after AW, BREADY stalled
        loopback = 1'b1;
        axi_write(32'h4, 32'h6, 4'hF, 0, 1, 2);
        rd_chk(32'h0, 32'h000);
        rd_chk(32'h8, 32'h1);
        poll_rx_valid();
        axi_read(32'h0, 32'h106, 1'b1, 3, rd_dummy);
        rd_chk(32'h0, 32'h006);
        idle_cycles(30);

        // Back-to-back sends: the second is dropped while busy
        wr(32'h4, 32'h55);
        wr(32'h4, 32'hAA);
        idle_cycles(200);
        rd_chk(32'h8, 32'h2);
        rd_chk(32'h0, 32'h155);
        idle_cycles(200);
        rd_chk(32'h8, 32'h0);

        // Two bytes without reading: overrun, newest byte kept
        wr(32'h4, 32'h12);
        idle_cycles(170);
        wr(32'h4, 32'h34);
        idle_cycles(200);
        rd_chk(32'h8, 32'h6);
        rd_chk(32'h0, 32'h134);
        rd_chk(32'h8, 32'h0);

        // External frame with a bad stop bit, then a start-bit glitch
        loopback = 1'b0;
        send_rx_frame(8'hA5, 1'b0);
        idle_cycles(20);
        rd_chk(32'h8, 32'hA);
        rd_chk(32'h8, 32'h2);
        rd_chk(32'h0, 32'h1A5);
        rxd_drive = 1'b0;
        idle_cycles(3);
        rxd_drive = 1'b1;
        idle_cycles(200);
        rd_chk(32'h0, 32'h0A5);

        // BAUD clamping, byte strobes and handshake orderings
        wr(32'hC, 32'h2);
        rd_chk(32'hC, 32'h4);
        axi_write(32'hC, 32'h0000_0123, 4'h1, 0, 0, 0);
        rd_chk(32'hC, 32'h23);
        axi_write(32'hC, 32'h0000_0220, 4'h3, 2, 0, 1);
        rd_chk(32'hC, 32'h220);
        axi_write(32'hC, 32'h0000_0010, 4'hF, 1, 1, 0);
        rd_chk(32'hC, 32'h10);

        // TXDATA write without byte 0 strobe does not launch
        axi_write(32'h4, 32'h77, 4'hE, 0, 0, 0);
        rd_chk(32'h8, 32'h0);

        // Reset in the middle of a frame
        loopback = 1'b1;
        wr(32'h4, 32'h00);
        idle_cycles(20);
        checkOutput("txd_mid_frame", {31'b0, txd}, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("txd_async_reset", {31'b0, txd}, 32'd1);
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(2);
        rd_chk(32'h8, 32'h0);
        rd_chk(32'hC, 32'h10);
        idle_cycles(300);
        rd_chk(32'h0, 32'h000);
    endtask

    // Main sequence: reset checks, directed tests, summary
    initial begin
        rst       = 1'b1;
        awaddr    = '0;
        awprot    = '0;
        awvalid   = 1'b0;
        wdata     = '0;
        wstrb     = '0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        araddr    = '0;
        arprot    = '0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rxd_drive = 1'b1;
        loopback  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_txd", {31'b0, txd}, 32'd1);
        checkOutput("reset_awready", {31'b0, awready}, 32'd0);
        checkOutput("reset_bvalid", {31'b0, bvalid}, 32'd0);
        checkOutput("reset_rvalid", {31'b0, rvalid}, 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(2);
        applyStimulus();
        idle_cycles(5);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #500000;
        tests_run++;
        fail_count++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
